// File: rtl/adder_stream_pkg.sv
// Shared definitions for the adder output word stream.
// Holds the 32-bit word field layout, the fill pattern, the unpacked result
// width and the accumulator FSM state encoding.
package adder_stream_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned VAL_W     = 17;

    localparam int unsigned CARRY_BIT = 31;
    localparam int unsigned FILL_HI   = 30;
    localparam int unsigned FILL_LO   = 16;
    localparam int unsigned SUM_HI    = 15;
    localparam int unsigned SUM_LO    = 0;

    localparam logic [14:0] FILL_PATTERN = 15'h0fff;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ACCUM = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/adder_result_accum_if.sv
// Stream interface between the adder stage, the accumulator and its consumer.
//   data_in/in_valid/in_ready    : word stream from the adder stage
//   acc_out/acc_valid/acc_ready  : window total towards the consumer
// master = producer/consumer side (testbench or neighbouring blocks),
// slave  = adder_result_accum.
interface adder_result_accum_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ACC_W = 20
);
    logic [WIDTH-1:0] data_in;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;

    modport master (
        output data_in, in_valid, acc_ready,
        input  in_ready, acc_out, acc_valid
    );

    modport slave (
        input  data_in, in_valid, acc_ready,
        output in_ready, acc_out, acc_valid
    );
endinterface

// File: rtl/adder_word_unpack.sv
// Combinational field split of one adder output word.
//   data_in : 32-bit word {carry, fill[14:0], sum[15:0]}
//   val     : rebuilt 17-bit result {carry, sum}
//   fill_ok : fill field equals the expected pattern
module adder_word_unpack
    import adder_stream_pkg::*;
(
    input  logic [WORD_W-1:0] data_in,
    output logic [VAL_W-1:0]  val,
    output logic              fill_ok
);
    assign val     = {data_in[CARRY_BIT], data_in[SUM_HI:SUM_LO]};
    assign fill_ok = (data_in[FILL_HI:FILL_LO] == FILL_PATTERN);
endmodule

// File: rtl/adder_result_accum.sv
// Accumulates the {carry, sum} results of WINDOW adder words and presents the
// window total on a valid/ready port.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : opens a window (honoured in IDLE only)
//   bus        : slave side of adder_result_accum_if (word in, total out)
//   overflow   : current/last window exceeded 2^ACC_W-1
//   frame_err  : sticky fill-field mismatch within the window
//   busy       : FSM not in IDLE
// Build option: define ACC_SAT_EN to clamp the accumulator at 2^ACC_W-1 on
// overflow instead of wrapping modulo 2^ACC_W.
module adder_result_accum
    import adder_stream_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned WINDOW = 16,
    parameter int unsigned ACC_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    adder_result_accum_if.slave   bus,
    output logic                  overflow,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    if (WIDTH != WORD_W) begin : g_width_chk
        $error("adder_result_accum: WIDTH must be 32");
    end
    if (WINDOW < 2 || WINDOW > 256) begin : g_window_chk
        $error("adder_result_accum: WINDOW must be in 2..256");
    end
    if (ACC_W < VAL_W) begin : g_accw_chk
        $error("adder_result_accum: ACC_W must hold a 17-bit result");
    end

    state_t            state;
    state_t            state_nxt;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic [ACC_W-1:0]  acc_out_q;
    logic              acc_valid_q;
    logic              in_ready_q;
    logic              accept_c;
    logic              last_c;
    logic [VAL_W-1:0]  val;
    logic              fill_ok;
    logic [ACC_W:0]    sum_c;
    logic              ovf_c;
    logic [ACC_W-1:0]  acc_nxt_c;

    adder_word_unpack u_unpack (
        .data_in (bus.data_in),
        .val     (val),
        .fill_ok (fill_ok)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.acc_valid = acc_valid_q;

    // Extra top bit of the sum is the overflow indicator for this word.
    always_comb begin
        sum_c = {1'b0, acc} + (ACC_W+1)'(val);
        ovf_c = sum_c[ACC_W];
`ifdef ACC_SAT_EN
        acc_nxt_c = (ovf_c || overflow) ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];
`else
        acc_nxt_c = sum_c[ACC_W-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        last_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                accept_c = bus.in_valid;
                last_c   = bus.in_valid && (count == LAST_CNT);
                if (last_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.acc_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, flags and registered port outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            count       <= '0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            overflow    <= 1'b0;
            frame_err   <= 1'b0;
            in_ready_q  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            in_ready_q <= (state_nxt == ACCUM);
            busy       <= (state_nxt != IDLE);
            if (state == IDLE && start) begin
                acc       <= '0;
                count     <= '0;
                overflow  <= 1'b0;
                frame_err <= 1'b0;
            end else if (accept_c) begin
                acc      <= acc_nxt_c;
                count    <= last_c ? '0 : count + CNT_W'(1);
                overflow <= overflow | ovf_c;
                if (!fill_ok) begin
                    frame_err <= 1'b1;
                end
                if (last_c) begin
                    acc_out_q   <= acc_nxt_c;
                    acc_valid_q <= 1'b1;
                end
            end else if (state == DONE && bus.acc_ready) begin
                acc_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_result_accum.sv
// Directed self-checking bench for adder_result_accum.
module tb_adder_result_accum;
    logic clk;
    logic rst;
    logic start;
    logic overflow;
    logic frame_err;
    logic busy;
    int   checks;
    int   errors;

    adder_result_accum_if #(.WIDTH(32), .ACC_W(20)) bus ();

    adder_result_accum #(.WIDTH(32), .WINDOW(16), .ACC_W(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .overflow  (overflow),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // 16 x 0x1ffff = 0x1ffff0: clamps to 0xfffff, or wraps to 0xffff0.
`ifdef ACC_SAT_EN
    localparam logic [19:0] CARRY_EXP = 20'hfffff;
`else
    localparam logic [19:0] CARRY_EXP = 20'hffff0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Opens a window and offers 16 back-to-back words (15 x w, then last_w);
    // start is re-pulsed while offering word start_at (negative = never).
    task automatic run_words(input logic [31:0] w, input logic [31:0] last_w,
                             input int start_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.data_in  = (i == 15) ? last_w : w;
            bus.in_valid = 1'b1;
            start        = (i == start_at);
            tick();
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks += 6;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
        if (bus.acc_valid !== 1'b0) begin errors++; $display("FAIL rst_acc_valid got %b exp 0", bus.acc_valid); end
        if (bus.acc_out !== 20'h0) begin errors++; $display("FAIL rst_acc_out got %h exp 00000", bus.acc_out); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", overflow); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err got %b exp 0", frame_err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        bus.acc_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy got %b exp 1", busy); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL nom_in_ready got %b exp 1", bus.in_ready); end
        for (int i = 0; i < 16; i++) begin
            bus.data_in  = 32'h0fff_0001;
            bus.in_valid = 1'b1;
            tick();
            if (i == 14) begin
                checks++;
                if (bus.acc_valid !== 1'b0) begin errors++; $display("FAIL nom_early_valid got %b exp 0", bus.acc_valid); end
            end
        end
        bus.in_valid = 1'b0;
        checks += 5;
        if (bus.acc_valid !== 1'b1) begin errors++; $display("FAIL nom_acc_valid got %b exp 1", bus.acc_valid); end
        if (bus.acc_out !== 20'h00010) begin errors++; $display("FAIL nom_acc_out got %h exp 00010", bus.acc_out); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL nom_overflow got %b exp 0", overflow); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL nom_frame_err got %b exp 0", frame_err); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL nom_done_in_ready got %b exp 0", bus.in_ready); end
        tick();
        checks += 2;
        if (bus.acc_valid !== 1'b0) begin errors++; $display("FAIL nom_valid_drop got %b exp 0", bus.acc_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL nom_idle got %b exp 0", busy); end
    endtask

    task automatic test_carry();
        bus.acc_ready = 1'b1;
        run_words(32'h8fff_ffff, 32'h8fff_ffff, -1);
        checks += 3;
        if (bus.acc_out !== CARRY_EXP) begin errors++; $display("FAIL carry_acc_out got %h exp %h", bus.acc_out, CARRY_EXP); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL carry_overflow got %b exp 1", overflow); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL carry_frame_err got %b exp 0", frame_err); end
        tick();
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL carry_ovf_hold got %b exp 1", overflow); end
    endtask

    task automatic test_frame_err();
        bus.acc_ready = 1'b1;
        run_words(32'h0fff_0002, 32'h0000_0005, -1);
        checks += 3;
        if (bus.acc_out !== 20'h00023) begin errors++; $display("FAIL frm_acc_out got %h exp 00023", bus.acc_out); end
        if (frame_err !== 1'b1) begin errors++; $display("FAIL frm_frame_err got %b exp 1", frame_err); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL frm_ovf_cleared got %b exp 0", overflow); end
        tick();
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL frm_sticky got %b exp 1", frame_err); end
    endtask

    task automatic test_backpressure();
        bus.acc_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL bp_frame_clear got %b exp 0", frame_err); end
        // Valid on even cycles only: 16 accepts over 31 cycles.
        for (int c = 0; c < 31; c++) begin
            bus.data_in  = 32'h0fff_0003;
            bus.in_valid = (c % 2 == 0);
            tick();
            if (c == 29) begin
                checks++;
                if (bus.acc_valid !== 1'b0) begin errors++; $display("FAIL bp_early_valid got %b exp 0", bus.acc_valid); end
            end
        end
        checks += 2;
        if (bus.acc_valid !== 1'b1) begin errors++; $display("FAIL bp_acc_valid got %b exp 1", bus.acc_valid); end
        if (bus.acc_out !== 20'h00030) begin errors++; $display("FAIL bp_acc_out got %h exp 00030", bus.acc_out); end
        bus.in_valid = 1'b1;
        bus.data_in  = 32'h0fff_0007;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks += 4;
            if (bus.acc_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b exp 1", bus.acc_valid); end
            if (bus.acc_out !== 20'h00030) begin errors++; $display("FAIL bp_hold_out got %h exp 00030", bus.acc_out); end
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready got %b exp 0", bus.in_ready); end
            if (busy !== 1'b1) begin errors++; $display("FAIL bp_hold_busy got %b exp 1", busy); end
        end
        bus.in_valid  = 1'b0;
        bus.acc_ready = 1'b1;
        tick();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got %b exp 0", busy); end
        if (bus.acc_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %b exp 0", bus.acc_valid); end
    endtask

    task automatic test_reset_mid();
        bus.acc_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.data_in  = 32'h8fff_ffff;
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL rm_pre_ovf got %b exp 0", overflow); end
        #2 rst = 1'b1;
        #1;
        checks += 6;
        if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", busy); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rm_in_ready got %b exp 0", bus.in_ready); end
        if (bus.acc_valid !== 1'b0) begin errors++; $display("FAIL rm_acc_valid got %b exp 0", bus.acc_valid); end
        if (bus.acc_out !== 20'h0) begin errors++; $display("FAIL rm_acc_out got %h exp 00000", bus.acc_out); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rm_overflow got %b exp 0", overflow); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL rm_frame_err got %b exp 0", frame_err); end
        #1 rst = 1'b0;
        tick();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL rm_stay_idle got %b exp 0", busy); end
        if (bus.acc_valid !== 1'b0) begin errors++; $display("FAIL rm_no_valid got %b exp 0", bus.acc_valid); end
        bus.acc_ready = 1'b1;
        run_words(32'h0fff_0004, 32'h0fff_0004, -1);
        checks += 3;
        if (bus.acc_valid !== 1'b1) begin errors++; $display("FAIL rm_win_valid got %b exp 1", bus.acc_valid); end
        if (bus.acc_out !== 20'h00040) begin errors++; $display("FAIL rm_win_out got %h exp 00040", bus.acc_out); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rm_win_ovf got %b exp 0", overflow); end
        tick();
    endtask

    task automatic test_ignored_start();
        bus.acc_ready = 1'b1;
        run_words(32'h0fff_0005, 32'h0fff_0005, 4);
        checks += 2;
        if (bus.acc_valid !== 1'b1) begin errors++; $display("FAIL ign_valid got %b exp 1", bus.acc_valid); end
        if (bus.acc_out !== 20'h00050) begin errors++; $display("FAIL ign_acc_out got %h exp 00050", bus.acc_out); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL ign_handshake_idle got %b exp 0", busy); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ign_in_ready got %b exp 0", bus.in_ready); end
        tick();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart got %b exp 0", busy); end
        if (bus.acc_out !== 20'h00050) begin errors++; $display("FAIL ign_out_kept got %h exp 00050", bus.acc_out); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        start         = 1'b0;
        bus.data_in   = '0;
        bus.in_valid  = 1'b0;
        bus.acc_ready = 1'b0;
        test_reset();
        test_nominal();
        test_carry();
        test_frame_err();
        test_backpressure();
        test_reset_mid();
        test_ignored_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
